mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_pkg.sv | 53 +++++
 rtl/load_formatter.sv | 33 +++
 rtl/mem_stage.sv | 105 ++++++++++
 tb/tb_mem_stage.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: funct3 access codes, control-bit
// positions and helpers that classify an access by size and alignment.
package mem_stage_pkg;

   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;
   localparam logic [2:0] SB  = 3'b000;
   localparam logic [2:0] SH  = 3'b001;
   localparam logic [2:0] SW  = 3'b010;

   localparam int MEMREAD  = 3;
   localparam int MEMWRITE = 2;
   localparam int REGWRITE = 1;
   localparam int MEMTOREG = 0;

   typedef enum logic [1:0] {
      SIZE_BYTE,
      SIZE_HALF,
      SIZE_WORD,
      SIZE_NONE
   } access_size_e;

   // Unrecognised load codes fall back to a full-word access.
   function automatic access_size_e load_size(input logic [2:0] funct3);
      case (funct3)
         LB, LBU: load_size = SIZE_BYTE;
         LH, LHU: load_size = SIZE_HALF;
         default: load_size = SIZE_WORD;
      endcase
   endfunction

   // Unrecognised store codes touch no byte lanes at all.
   function automatic access_size_e store_size(input logic [2:0] funct3);
      case (funct3)
         SB:      store_size = SIZE_BYTE;
         SH:      store_size = SIZE_HALF;
         SW:      store_size = SIZE_WORD;
         default: store_size = SIZE_NONE;
      endcase
   endfunction

   function automatic logic is_misaligned(input access_size_e size, input logic [1:0] offset);
      case (size)
         SIZE_HALF: is_misaligned = offset[0];
         SIZE_WORD: is_misaligned = (offset != 2'b00);
         default:   is_misaligned = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/load_formatter.sv
// Combinational load alignment: picks the addressed byte or half out of a
// memory word and sign- or zero-extends it according to funct3.
module load_formatter
   import mem_stage_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  offset,
   input  logic [2:0]  funct3,
   output logic [31:0] value
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      case (offset)
         2'd0:    byte_sel = word[7:0];
         2'd1:    byte_sel = word[15:8];
         2'd2:    byte_sel = word[23:16];
         default: byte_sel = word[31:24];
      endcase
      half_sel = offset[1] ? word[31:16] : word[15:0];

      case (funct3)
         LB:      value = {{24{byte_sel[7]}}, byte_sel};
         LH:      value = {{16{half_sel[15]}}, half_sel};
         LBU:     value = {24'h0, byte_sel};
         LHU:     value = {16'h0, half_sel};
         default: value = word;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: byte-addressed data memory with asynchronous read,
// lane-masked stores, misalignment trapping and the MEM/WB register.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int MEM_WORDS = 256
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        stall_in,
   input  logic        flush_in,
   input  logic [3:0]  control_MEM_in,
   input  logic [2:0]  funct3_MEM_in,
   input  logic [31:0] ALU_result_MEM_in,
   input  logic [31:0] writeData_MEM_in,
   input  logic [4:0]  rd_MEM_in,
   output logic [1:0]  control_WB_out,
   output logic [31:0] readData_WB_out,
   output logic [31:0] ALU_result_WB_out,
   output logic [4:0]  rd_WB_out,
   output logic        misaligned_out
);

   localparam int IDX_W = $clog2(MEM_WORDS);

   logic [31:0]      mem [MEM_WORDS];
   logic [IDX_W-1:0] word_idx;
   logic [1:0]       offset;
   logic             mem_read;
   logic             mem_write;
   logic             misaligned;
   logic             write_en;
   access_size_e     ld_size;
   access_size_e     st_size;
   logic [31:0]      rd_word;
   logic [31:0]      load_value;
   logic [31:0]      store_data;
   logic [3:0]       lane_en;

   // Address bits above the memory size are ignored, so accesses wrap.
   assign word_idx  = ALU_result_MEM_in[IDX_W+1:2];
   assign offset    = ALU_result_MEM_in[1:0];
   assign mem_read  = control_MEM_in[MEMREAD];
   assign mem_write = control_MEM_in[MEMWRITE];
   assign ld_size   = load_size(funct3_MEM_in);
   assign st_size   = store_size(funct3_MEM_in);
   assign rd_word   = mem[word_idx];

   assign misaligned = (mem_read  && is_misaligned(ld_size, offset))
                    || (mem_write && is_misaligned(st_size, offset));

   load_formatter u_load_formatter (
      .word   (rd_word),
      .offset (offset),
      .funct3 (funct3_MEM_in),
      .value  (load_value)
   );

   // Store data is replicated across lanes so the lane mask alone picks the target bytes.
   always_comb begin
      lane_en    = 4'b0000;
      store_data = writeData_MEM_in;
      case (st_size)
         SIZE_BYTE: begin
            lane_en    = 4'b0001 << offset;
            store_data = {4{writeData_MEM_in[7:0]}};
         end
         SIZE_HALF: begin
            lane_en    = offset[1] ? 4'b1100 : 4'b0011;
            store_data = {2{writeData_MEM_in[15:0]}};
         end
         SIZE_WORD: lane_en = 4'b1111;
         default:   lane_en = 4'b0000;
      endcase
      write_en = mem_write && !misaligned && reset_n && !flush_in && !stall_in;
   end

   // Memory contents survive reset; only the commit is gated.
   always_ff @(posedge clock) begin
      if (write_en) begin
         for (int lane = 0; lane < 4; lane++) begin
            if (lane_en[lane]) begin
               mem[word_idx][8*lane +: 8] <= store_data[8*lane +: 8];
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n || flush_in) begin
         control_WB_out    <= 2'b00;
         readData_WB_out   <= 32'h0;
         ALU_result_WB_out <= 32'h0;
         rd_WB_out         <= 5'd0;
         misaligned_out    <= 1'b0;
      end else if (!stall_in) begin
         control_WB_out    <= {control_MEM_in[REGWRITE] & ~misaligned, control_MEM_in[MEMTOREG]};
         readData_WB_out   <= (mem_read && !misaligned) ? load_value : 32'h0;
         ALU_result_WB_out <= ALU_result_MEM_in;
         rd_WB_out         <= rd_MEM_in;
         misaligned_out    <= misaligned;
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed vector table, hand-written stall/flush/reset
// sequences and a randomized run against a byte-addressed reference model.
module tb_mem_stage;
   import mem_stage_pkg::*;

   localparam int MEM_WORDS = 256;
   localparam int MEM_BYTES = MEM_WORDS * 4;
   localparam logic [3:0] C_LOAD  = 4'b1011;
   localparam logic [3:0] C_STORE = 4'b0100;
   localparam logic [3:0] C_ALU   = 4'b0010;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        stall_in;
   logic        flush_in;
   logic [3:0]  control_MEM_in;
   logic [2:0]  funct3_MEM_in;
   logic [31:0] ALU_result_MEM_in;
   logic [31:0] writeData_MEM_in;
   logic [4:0]  rd_MEM_in;
   logic [1:0]  control_WB_out;
   logic [31:0] readData_WB_out;
   logic [31:0] ALU_result_WB_out;
   logic [4:0]  rd_WB_out;
   logic        misaligned_out;

   always #5 clock = ~clock;

   mem_stage #(.MEM_WORDS(MEM_WORDS)) dut (
      .clock             (clock),
      .reset_n           (reset_n),
      .stall_in          (stall_in),
      .flush_in          (flush_in),
      .control_MEM_in    (control_MEM_in),
      .funct3_MEM_in     (funct3_MEM_in),
      .ALU_result_MEM_in (ALU_result_MEM_in),
      .writeData_MEM_in  (writeData_MEM_in),
      .rd_MEM_in         (rd_MEM_in),
      .control_WB_out    (control_WB_out),
      .readData_WB_out   (readData_WB_out),
      .ALU_result_WB_out (ALU_result_WB_out),
      .rd_WB_out         (rd_WB_out),
      .misaligned_out    (misaligned_out)
   );

   typedef struct {
      logic        rst_n;
      logic        stall;
      logic        flush;
      logic [3:0]  ctrl;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [4:0]  rd;
   } stim_t;

   typedef struct {
      stim_t       s;
      logic        chk;
      logic [1:0]  e_ctrl;
      logic [31:0] e_rdata;
      logic        e_mis;
   } vec_t;

   logic [7:0]  model_mem [MEM_BYTES];
   logic [1:0]  m_ctrl;
   logic [31:0] m_rdata;
   logic [31:0] m_alu;
   logic [4:0]  m_rd;
   logic        m_mis;
   int          errors = 0;
   int          checks = 0;
   vec_t        vecs[$];

   function automatic stim_t mk(input logic rst_n, input logic stall, input logic flush,
                                input logic [3:0] ctrl, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [4:0] rd);
      stim_t s;
      s.rst_n = rst_n; s.stall = stall; s.flush = flush; s.ctrl = ctrl;
      s.f3 = f3; s.addr = addr; s.wdata = wdata; s.rd = rd;
      return s;
   endfunction

   function automatic void addVec(input stim_t s, input logic [1:0] e_ctrl,
                                  input logic [31:0] e_rdata, input logic e_mis);
      vec_t v;
      v.s = s; v.chk = 1'b1; v.e_ctrl = e_ctrl; v.e_rdata = e_rdata; v.e_mis = e_mis;
      vecs.push_back(v);
   endfunction

   // Reference: the memory is a flat byte array; loads read before the same-edge store lands.
   task automatic modelEdge(input stim_t s);
      int unsigned a;
      int unsigned lsz;
      int unsigned ssz;
      logic        mis;
      logic [31:0] v;
      if (!s.rst_n || s.flush) begin
         m_ctrl = 2'b00; m_rdata = 32'h0; m_alu = 32'h0; m_rd = 5'd0; m_mis = 1'b0;
         return;
      end
      if (s.stall) return;
      a = s.addr % MEM_BYTES;
      case (s.f3)
         3'b000, 3'b100: lsz = 1;
         3'b001, 3'b101: lsz = 2;
         default:        lsz = 4;
      endcase
      case (s.f3)
         3'b000:  ssz = 1;
         3'b001:  ssz = 2;
         3'b010:  ssz = 4;
         default: ssz = 0;
      endcase
      mis = (s.ctrl[3] && (a % lsz) != 0) || (s.ctrl[2] && ssz != 0 && (a % ssz) != 0);
      v = 32'h0;
      if (s.ctrl[3] && !mis) begin
         for (int i = 0; i < int'(lsz); i++) v = v | (32'(model_mem[a + i]) << (8 * i));
         if (lsz < 4 && (s.f3 == 3'b000 || s.f3 == 3'b001) && v[8*lsz-1])
            v = v | (32'hFFFF_FFFF << (8 * lsz));
      end
      if (s.ctrl[2] && !mis) begin
         for (int i = 0; i < int'(ssz); i++) model_mem[a + i] = s.wdata[8*i +: 8];
      end
      m_ctrl  = {s.ctrl[1] & ~mis, s.ctrl[0]};
      m_rdata = v;
      m_alu   = s.addr;
      m_rd    = s.rd;
      m_mis   = mis;
   endtask

   task automatic applyStimulus(input stim_t s);
      @(negedge clock);
      reset_n           = s.rst_n;
      stall_in          = s.stall;
      flush_in          = s.flush;
      control_MEM_in    = s.ctrl;
      funct3_MEM_in     = s.f3;
      ALU_result_MEM_in = s.addr;
      writeData_MEM_in  = s.wdata;
      rd_MEM_in         = s.rd;
      @(posedge clock);
      modelEdge(s);
      #2;
   endtask

   task automatic checkOutput(input string name);
      checks++;
      if (control_WB_out !== m_ctrl || readData_WB_out !== m_rdata || ALU_result_WB_out !== m_alu
          || rd_WB_out !== m_rd || misaligned_out !== m_mis) begin
         errors++;
         $display("[TB] FAIL %s: got ctrl=%b rdata=%h alu=%h rd=%0d mis=%b, expected ctrl=%b rdata=%h alu=%h rd=%0d mis=%b",
                  name, control_WB_out, readData_WB_out, ALU_result_WB_out, rd_WB_out, misaligned_out,
                  m_ctrl, m_rdata, m_alu, m_rd, m_mis);
      end
   endtask

   task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic checkAllZero(input string name);
      checkValue({name, "_ctrl"}, 32'(control_WB_out), 32'h0);
      checkValue({name, "_rdata"}, readData_WB_out, 32'h0);
      checkValue({name, "_alu"}, ALU_result_WB_out, 32'h0);
      checkValue({name, "_rd"}, 32'(rd_WB_out), 32'h0);
      checkValue({name, "_mis"}, 32'(misaligned_out), 32'h0);
   endtask

   initial begin
      stim_t s;
      logic [31:0] r;

      // Reset state
      applyStimulus(mk(1'b0, 1'b0, 1'b0, 4'h0, 3'h0, 32'h0, 32'h0, 5'd0));
      applyStimulus(mk(1'b0, 1'b0, 1'b0, C_STORE, SW, 32'h40, 32'h1234_5678, 5'd3));
      checkAllZero("reset_state");

      // Give every memory word a known value
      for (int i = 0; i < MEM_WORDS; i++) begin
         applyStimulus(mk(1'b1, 1'b0, 1'b0, C_STORE, SW, 32'(i * 4), $urandom, 5'(i)));
      end
      checkOutput("init_last_store");

      // Directed vectors with hand-computed expectations
      addVec(mk(1, 0, 0, C_STORE, SW, 32'h10, 32'h8000_00F1, 5'd1), 2'b00, 32'h0, 1'b0);
      addVec(mk(1, 0, 0, C_LOAD, LB, 32'h10, 32'h0, 5'd2), 2'b11, 32'hFFFF_FFF1, 1'b0);
      addVec(mk(1, 0, 0, C_LOAD, LBU, 32'h10, 32'h0, 5'd3), 2'b11, 32'h0000_00F1, 1'b0);
      addVec(mk(1, 0, 0, C_STORE, SW, 32'h20, 32'h1122_3344, 5'd4), 2'b00, 32'h0, 1'b0);
      addVec(mk(1, 0, 0, C_STORE, SH, 32'h22, 32'h0000_BEEF, 5'd5), 2'b00, 32'h0, 1'b0);
      addVec(mk(1, 0, 0, C_LOAD, LW, 32'h20, 32'h0, 5'd6), 2'b11, 32'hBEEF_3344, 1'b0);
      addVec(mk(1, 0, 0, C_LOAD, LW, 32'h13, 32'h0, 5'd7), 2'b01, 32'h0, 1'b1);
      addVec(mk(1, 0, 0, 4'b0110, SW, 32'h13, 32'hDEAD_BEEF, 5'd8), 2'b00, 32'h0, 1'b1);
      addVec(mk(1, 0, 0, C_LOAD, LW, 32'h10, 32'h0, 5'd9), 2'b11, 32'h8000_00F1, 1'b0);
      addVec(mk(1, 0, 0, C_LOAD, LH, 32'h11, 32'h0, 5'd10), 2'b01, 32'h0, 1'b1);
      addVec(mk(1, 0, 0, C_LOAD, LHU, 32'h22, 32'h0, 5'd11), 2'b11, 32'h0000_BEEF, 1'b0);
      addVec(mk(1, 0, 0, C_LOAD, LH, 32'h22, 32'h0, 5'd12), 2'b11, 32'hFFFF_BEEF, 1'b0);
      addVec(mk(1, 0, 0, C_STORE, 3'b011, 32'h10, 32'h0, 5'd13), 2'b00, 32'h0, 1'b0);
      addVec(mk(1, 0, 0, C_LOAD, 3'b011, 32'h10, 32'h0, 5'd14), 2'b11, 32'h8000_00F1, 1'b0);
      addVec(mk(1, 0, 0, C_LOAD, LB, 32'h23, 32'h0, 5'd15), 2'b11, 32'hFFFF_FFBE, 1'b0);
      addVec(mk(1, 0, 0, C_ALU, LW, 32'h1234_5678, 32'h0, 5'd16), 2'b10, 32'h0, 1'b0);
      addVec(mk(1, 0, 0, C_STORE, SW, 32'h400, 32'hCAFE_F00D, 5'd17), 2'b00, 32'h0, 1'b0);
      addVec(mk(1, 0, 0, C_LOAD, LW, 32'h000, 32'h0, 5'd18), 2'b11, 32'hCAFE_F00D, 1'b0);
      addVec(mk(1, 0, 0, C_STORE, SB, 32'h401, 32'h0000_005A, 5'd19), 2'b00, 32'h0, 1'b0);
      addVec(mk(1, 0, 0, C_LOAD, LW, 32'h000, 32'h0, 5'd20), 2'b11, 32'hCAFE_5A0D, 1'b0);
      addVec(mk(1, 0, 0, 4'b0011, LW, 32'h10, 32'h0, 5'd21), 2'b11, 32'h0, 1'b0);

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].s);
         checkOutput($sformatf("vec%0d_model", i));
         if (vecs[i].chk) begin
            checkValue($sformatf("vec%0d_ctrl", i), 32'(control_WB_out), 32'(vecs[i].e_ctrl));
            checkValue($sformatf("vec%0d_rdata", i), readData_WB_out, vecs[i].e_rdata);
            checkValue($sformatf("vec%0d_mis", i), 32'(misaligned_out), 32'(vecs[i].e_mis));
            checkValue($sformatf("vec%0d_rd", i), 32'(rd_WB_out), 32'(vecs[i].s.rd));
         end
      end

      // Stall holds outputs and writes exactly once on release
      applyStimulus(mk(1, 0, 0, C_ALU, LW, 32'h55, 32'h0, 5'd9));
      for (int i = 0; i < 3; i++) begin
         applyStimulus(mk(1, 1, 0, C_STORE, SW, 32'h40, 32'hA1B2_C3D4, 5'd3));
         checkValue($sformatf("stall%0d_alu", i), ALU_result_WB_out, 32'h55);
         checkValue($sformatf("stall%0d_rd", i), 32'(rd_WB_out), 32'd9);
         checkValue($sformatf("stall%0d_ctrl", i), 32'(control_WB_out), 32'h2);
      end
      applyStimulus(mk(1, 0, 0, C_STORE, SW, 32'h40, 32'hA1B2_C3D4, 5'd3));
      checkValue("release_alu", ALU_result_WB_out, 32'h40);
      checkValue("release_rd", 32'(rd_WB_out), 32'd3);
      applyStimulus(mk(1, 0, 0, C_LOAD, LW, 32'h40, 32'h0, 5'd4));
      checkValue("after_stall_load", readData_WB_out, 32'hA1B2_C3D4);

      // A stalled store that is abandoned never reaches memory
      applyStimulus(mk(1, 0, 0, C_STORE, SW, 32'h44, 32'h0, 5'd1));
      applyStimulus(mk(1, 1, 0, C_STORE, SB, 32'h44, 32'h77, 5'd1));
      applyStimulus(mk(1, 1, 0, C_STORE, SB, 32'h44, 32'h77, 5'd1));
      applyStimulus(mk(1, 0, 0, C_LOAD, LW, 32'h44, 32'h0, 5'd2));
      checkValue("stalled_store_dropped", readData_WB_out, 32'h0);

      // Flush beats stall and blocks the store
      applyStimulus(mk(1, 1, 1, C_STORE, SW, 32'h40, 32'hFFFF_FFFF, 5'd4));
      checkAllZero("flush");
      applyStimulus(mk(1, 0, 0, C_LOAD, LW, 32'h40, 32'h0, 5'd5));
      checkValue("after_flush_load", readData_WB_out, 32'hA1B2_C3D4);

      // Reset beats stall/flush and blocks the pending store
      applyStimulus(mk(0, 1, 0, C_STORE, SW, 32'h40, 32'h1212_1212, 5'd6));
      checkAllZero("mid_reset");
      applyStimulus(mk(1, 0, 0, C_LOAD, LW, 32'h40, 32'h0, 5'd7));
      checkValue("after_reset_load", readData_WB_out, 32'hA1B2_C3D4);
      checkOutput("after_reset_model");

      // Randomized traffic against the reference model
      for (int i = 0; i < 400; i++) begin
         s.rst_n = ($urandom_range(0, 99) >= 3);
         s.stall = ($urandom_range(0, 99) < 10);
         s.flush = ($urandom_range(0, 99) < 5);
         s.ctrl  = 4'($urandom_range(0, 15));
         s.f3    = 3'($urandom_range(0, 7));
         r       = $urandom;
         s.addr  = r & 32'hFFFF_F03F;
         if ($urandom_range(0, 1) == 1) s.addr[1:0] = 2'b00;
         s.wdata = $urandom;
         s.rd    = 5'($urandom_range(0, 31));
         applyStimulus(s);
         checkOutput($sformatf("rand%0d", i));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
